// File: rtl/regwb_pkg.sv
// Shared CPU constants and write-port source encoding.
// Imported by the writeback arbiter and its queue.
package regwb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;
  localparam logic [RAW_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_LT,
    SRC_DROP
  } wsrc_t;

endpackage

// File: rtl/regwb_fifo.sv
// Circular queue of long-latency results with per-entry live bits.
// Ports: push/pop, kill-by-register, match-by-register, head view, count.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  parameter int RAW   = RAW_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [RAW-1:0]  push_reg,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            kill,
  input  logic [RAW-1:0]  kill_reg,
  input  logic [RAW-1:0]  match_reg,
  output logic            match,
  output logic            head_live,
  output logic [RAW-1:0]  head_reg,
  output logic [XLEN-1:0] head_data,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [RAW-1:0]  regs [DEPTH];
  logic [XLEN-1:0] data [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  assign head_live = live[head];
  assign head_reg  = regs[head];
  assign head_data = data[head];

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i] && regs[i] == match_reg)
        match = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      regs[tail] <= push_reg;
      data[tail] <= push_data;
    end
  end

  // Push is applied last: the new entry is younger than the kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (kill)
        for (int i = 0; i < DEPTH; i++)
          if (regs[i] == kill_reg)
            live[i] <= 1'b0;
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      if (push) begin
        live[tail] <= 1'b1;
        tail       <= tail + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regwb.sv
// Register-file write-port arbiter: pipeline writeback beats a queued
// long-latency unit; drives regwrite/wrreg/wrdata and a hazard query.
module regwb
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  parameter int RAW   = RAW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [RAW-1:0]  wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lt_valid,
  output logic            lt_ready,
  input  logic [RAW-1:0]  lt_reg,
  input  logic [XLEN-1:0] lt_data,
  output logic            regwrite,
  output logic [RAW-1:0]  wrreg,
  output logic [XLEN-1:0] wrdata,
  input  logic [RAW-1:0]  qreg,
  output logic            qhit,
  output logic            drain_req
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   count;
  logic            head_live;
  logic [RAW-1:0]  head_reg;
  logic [XLEN-1:0] head_data;
  logic            match;
  logic            wb_req;
  logic            nonempty;
  logic            push;
  logic            pop;
  wsrc_t           src;

  assign wb_req    = wb_valid && wb_reg != '0;
  assign nonempty  = count != '0;
  assign lt_ready  = count < CW'(DEPTH);
  assign drain_req = count == CW'(DEPTH);
  assign qhit      = match && qreg != '0;

  // Register 0 results complete the handshake but are dropped.
  assign push = lt_valid && lt_ready && lt_reg != '0;

  // A dead head leaves even while the pipeline owns the port.
  assign pop = nonempty && (!wb_req || !head_live);

  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      wb_req:                             src = SRC_WB;
      !wb_req && nonempty && head_live:   src = SRC_LT;
      !wb_req && nonempty && !head_live:  src = SRC_DROP;
      default:                            src = SRC_NONE;
    endcase
  end

  regwb_fifo #(
    .DEPTH(DEPTH),
    .XLEN (XLEN),
    .RAW  (RAW),
    .CW   (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_reg (lt_reg),
    .push_data(lt_data),
    .pop      (pop),
    .kill     (wb_req),
    .kill_reg (wb_reg),
    .match_reg(qreg),
    .match    (match),
    .head_live(head_live),
    .head_reg (head_reg),
    .head_data(head_data),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite <= 1'b0;
      wrreg    <= '0;
      wrdata   <= '0;
    end else begin
      regwrite <= 1'b0;
      wrreg    <= '0;
      wrdata   <= '0;
      if (src == SRC_WB) begin
        regwrite <= 1'b1;
        wrreg    <= wb_reg;
        wrdata   <= wb_data;
      end else if (src == SRC_LT) begin
        regwrite <= 1'b1;
        wrreg    <= head_reg;
        wrdata   <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_regwb.sv
// Bench for regwb: directed scenarios then random traffic, all checked
// against a queue-based model of the write-port rules.
module tb_regwb;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lt_valid;
  logic        lt_ready;
  logic [4:0]  lt_reg;
  logic [31:0] lt_data;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic [4:0]  qreg;
  logic        qhit;
  logic        drain_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rf [32];

  regwb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .lt_valid (lt_valid),
    .lt_ready (lt_ready),
    .lt_reg   (lt_reg),
    .lt_data  (lt_data),
    .regwrite (regwrite),
    .wrreg    (wrreg),
    .wrdata   (wrdata),
    .qreg     (qreg),
    .qhit     (qhit),
    .drain_req(drain_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: check state-derived outputs, apply the rules, then
  // check the write port after the edge.
  task automatic step();
    bit          lr;
    bit          qh;
    bit          wbreq;
    bit          ew;
    bit          dead_head;
    logic [4:0]  er;
    logic [31:0] ed;
    ent_t        e;
    #1;
    lr = q.size() < 4;
    chk("lt_ready", {31'd0, lt_ready}, {31'd0, lr});
    chk("drain_req", {31'd0, drain_req}, {31'd0, !lr});
    qh = 0;
    if (qreg != 0)
      foreach (q[i]) if (q[i].live && q[i].r == qreg) qh = 1;
    chk("qhit", {31'd0, qhit}, {31'd0, qh});
    wbreq = wb_valid && wb_reg != 0;
    ew = 0;
    er = 0;
    ed = 0;
    if (wbreq) begin
      ew = 1;
      er = wb_reg;
      ed = wb_data;
      dead_head = q.size() > 0 && !q[0].live;
      foreach (q[i]) if (q[i].r == wb_reg) begin
        e = q[i];
        e.live = 0;
        q[i] = e;
      end
      if (dead_head) void'(q.pop_front());
    end else if (q.size() > 0) begin
      if (q[0].live) begin
        ew = 1;
        er = q[0].r;
        ed = q[0].d;
      end
      void'(q.pop_front());
    end
    if (lt_valid && lr && lt_reg != 0) begin
      e.r = lt_reg;
      e.d = lt_data;
      e.live = 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("regwrite", {31'd0, regwrite}, {31'd0, ew});
    if (ew) begin
      chk("wrreg", {27'd0, wrreg}, {27'd0, er});
      chk("wrdata", wrdata, ed);
      rf[er] = ed;
    end
  endtask

  task automatic idle();
    wb_valid = 0;
    lt_valid = 0;
  endtask

  initial begin
    foreach (rf[i]) rf[i] = 0;
    rst_n = 0;
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    lt_valid = 0; lt_reg = 0; lt_data = 0;
    qreg = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_wrreg", {27'd0, wrreg}, 32'd0);
    chk("rst_wrdata", wrdata, 32'd0);
    chk("rst_lt_ready", {31'd0, lt_ready}, 32'd1);
    chk("rst_drain", {31'd0, drain_req}, 32'd0);
    chk("rst_qhit", {31'd0, qhit}, 32'd0);
    rst_n = 1;
    step();

    // Pipeline write
    wb_valid = 1; wb_reg = 8; wb_data = 32'hDEADBEEF;
    step();
    chk("wb_wrdata", wrdata, 32'hDEADBEEF);
    idle();
    step();

    // Fill and stall while the pipeline owns the port
    wb_valid = 1; wb_reg = 2; wb_data = 32'h22;
    lt_valid = 1;
    for (int i = 0; i < 4; i++) begin
      lt_reg = 5'(9 + i);
      lt_data = 32'h100 + i;
      step();
    end
    lt_reg = 13; lt_data = 32'h113;
    step();
    chk("full_drain", {31'd0, drain_req}, 32'd1);
    wb_valid = 0;
    step();
    step();
    lt_valid = 0;
    repeat (5) step();
    chk("fill_rf12", rf[12], 32'h103);

    // WAW kill
    wb_valid = 1; wb_reg = 3; wb_data = 32'h33;
    lt_valid = 1; lt_reg = 9; lt_data = 32'h1;
    qreg = 9;
    step();
    lt_valid = 0;
    wb_reg = 9; wb_data = 32'h2;
    step();
    idle();
    step();
    step();
    chk("waw_rf9", rf[9], 32'h2);

    // Register zero
    lt_valid = 1; lt_reg = 0; lt_data = 32'h55;
    step();
    lt_valid = 0;
    step();
    wb_valid = 1; wb_reg = 4; wb_data = 32'h44;
    lt_valid = 1; lt_reg = 6; lt_data = 32'h66;
    step();
    lt_valid = 0;
    wb_reg = 0; wb_data = 32'h99;
    step();
    chk("zero_drain_rf6", rf[6], 32'h66);
    idle();
    step();

    // Async reset mid-stream
    wb_valid = 1; wb_reg = 5; wb_data = 32'h77;
    lt_valid = 1;
    for (int i = 0; i < 3; i++) begin
      lt_reg = 5'(20 + i);
      lt_data = 32'h200 + i;
      step();
    end
    lt_valid = 0;
    qreg = 20;
    #2;
    rst_n = 0;
    #1;
    chk("arst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("arst_lt_ready", {31'd0, lt_ready}, 32'd1);
    chk("arst_drain", {31'd0, drain_req}, 32'd0);
    chk("arst_qhit", {31'd0, qhit}, 32'd0);
    q.delete();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (4) step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      wb_valid = $urandom_range(0, 99) < 60;
      wb_reg   = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      lt_valid = $urandom_range(0, 1) == 1;
      lt_reg   = 5'($urandom_range(0, 7));
      lt_data  = $urandom;
      qreg     = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
